// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving ALU, regfile, dmem and PC control.
// Latency: 2 cycles NOP/JMP, 3 BEQ/BNE, 4 ALU/ADDI/ST, 5 LD, plus one per imem_valid/dmem_ready wait cycle.
// Backpressure: imem_req held until imem_valid, dmem_req held until dmem_ready; CTRL_ILLEGAL_TRAP_EN makes illegal opcodes halt.
module control_fsm #(
   parameter int M    = 4,
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     imem_data,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ready,
   input  logic            zero_flag,
   output logic [M-1:0]    alu_opcode,
   output logic            alu_src_imm,
   output logic [2:0]      rd,
   output logic [2:0]      rs1,
   output logic [2:0]      rs2,
   output logic [15:0]     imm,
   output logic            reg_we,
   output logic            wb_sel,
   output logic            halted,
   output logic            illegal,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_JMP, OP_HALT,
      OP_LD, OP_ST, OP_ADDI, OP_BEQ, OP_BNE
   } op_t;

   state_t          state, state_n;
   logic [15:0]     ir, ir_n;
   logic [PC_W-1:0] pc_n, pc_inc, br_off;
   logic [3:0]      op;
   logic            op_illegal, br_taken;

   // Decoded fields come straight off the instruction register, so they are
   // valid from DECODE and stay stable until the next fetch completes.
   assign op          = ir[15:12];
   assign op_illegal  = (op > 4'd12);
   assign alu_opcode  = M'(op);
   assign rd          = ir[11:9];
   assign rs1         = ir[8:6];
   assign rs2         = ir[5:3];
   assign imm         = {{10{ir[5]}}, ir[5:0]};
   assign alu_src_imm = (op == OP_LD) || (op == OP_ST) || (op == OP_ADDI);

   assign pc_inc   = pc + PC_W'(1);
   assign br_off   = PC_W'($signed(ir[5:0]));
   assign br_taken = (op == OP_BEQ) ? zero_flag : ~zero_flag;

   assign imem_addr = pc;
   assign imem_req  = !rst && (state == S_FETCH);
   assign dmem_req  = !rst && (state == S_MEM);
   assign dmem_we   = !rst && (state == S_MEM) && (op == OP_ST);
   assign reg_we    = !rst && (state == S_WB);
   assign wb_sel    = !rst && (state == S_WB) && (op == OP_LD);
   assign illegal   = !rst && (state == S_DECODE) && op_illegal;
   assign halted    = (state == S_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         ir    <= '0;
         pc    <= '0;
      end else begin
         state <= state_n;
         ir    <= ir_n;
         pc    <= pc_n;
      end
   end

   always_comb begin
      state_n = state;
      ir_n    = ir;
      pc_n    = pc;
      case (state)
         S_FETCH: begin
            if (imem_valid) begin
               ir_n    = imem_data;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            case (op)
               OP_NOP: begin
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_JMP: begin
                  pc_n    = PC_W'(ir);
                  state_n = S_FETCH;
               end
               OP_HALT: state_n = S_HALT;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
               OP_LD, OP_ST, OP_ADDI, OP_BEQ, OP_BNE: state_n = S_EXECUTE;
               default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  state_n = S_HALT;
`else
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
`endif
               end
            endcase
         end
         S_EXECUTE: begin
            if ((op == OP_BEQ) || (op == OP_BNE)) begin
               pc_n    = br_taken ? (pc_inc + br_off) : pc_inc;
               state_n = S_FETCH;
            end else if ((op == OP_LD) || (op == OP_ST)) begin
               state_n = S_MEM;
            end else begin
               state_n = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (op == OP_ST) begin
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            pc_n    = pc_inc;
            state_n = S_FETCH;
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm; writeback events are scored against a queue of expectations.
module tb_control_fsm;
   localparam int M    = 4;
   localparam int PC_W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [15:0]     imem_data;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ready;
   logic            zero_flag;
   logic [M-1:0]    alu_opcode;
   logic            alu_src_imm;
   logic [2:0]      rd, rs1, rs2;
   logic [15:0]     imm;
   logic            reg_we;
   logic            wb_sel;
   logic            halted;
   logic            illegal;
   logic [PC_W-1:0] pc;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [2:0]      rd;
      logic            wb_sel;
      logic [PC_W-1:0] pc;
   } wb_exp_t;

   wb_exp_t exp_q[$];

   control_fsm #(.M(M), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .zero_flag(zero_flag), .alu_opcode(alu_opcode), .alu_src_imm(alu_src_imm),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .pc(pc)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_valid = 1'b0; imem_data = '0; dmem_ready = 1'b0; zero_flag = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   // Called in a FETCH cycle; returns in the DECODE cycle of the instruction.
   task automatic feed(input logic [15:0] w, input int dly);
      imem_data  = w;
      imem_valid = 1'b0;
      repeat (dly) step();
      imem_valid = 1'b1;
      step();
      imem_valid = 1'b0;
      imem_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_valid = 1'b1; imem_data = 16'h1298; dmem_ready = 1'b1; zero_flag = 1'b0;
      step();
      step();
      n_cmp++; if ({imem_req, dmem_req, reg_we} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {imem_req, dmem_req, reg_we}); end
      n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %0h want 0", pc); end
      n_cmp++; if (alu_opcode !== 4'h0) begin n_bad++; $display("FAIL reset_opcode: got %0h want 0", alu_opcode); end
      n_cmp++; if ({rd, rs1, rs2, imm, alu_src_imm, halted, illegal} !== 28'h0) begin n_bad++; $display("FAIL reset_fields: got %0h want 0", {rd, rs1, rs2, imm, alu_src_imm, halted, illegal}); end
      imem_valid = 1'b0; dmem_ready = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %b want 1", imem_req); end
      n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
   endtask

   task automatic test_add();
      wb_exp_t e;
      do_reset();
      // ADD r1,r2,r3
      exp_q.push_back({3'd1, 1'b0, 8'h00});
      feed(16'h1298, 0);
      n_cmp++; if (alu_opcode !== 4'd1) begin n_bad++; $display("FAIL add_opcode_decode: got %0h want 1", alu_opcode); end
      n_cmp++; if ({rd, rs1, rs2, alu_src_imm} !== {3'd1, 3'd2, 3'd3, 1'b0}) begin n_bad++; $display("FAIL add_fields: got %0h want %0h", {rd, rs1, rs2, alu_src_imm}, {3'd1, 3'd2, 3'd3, 1'b0}); end
      imem_valid = 1'b1; imem_data = 16'h7000;
      step();
      n_cmp++; if ({alu_opcode, reg_we} !== {4'd1, 1'b0}) begin n_bad++; $display("FAIL add_execute: got %0h want %0h", {alu_opcode, reg_we}, {4'd1, 1'b0}); end
      step();
      n_cmp++; if (reg_we !== 1'b1) begin n_bad++; $display("FAIL add_reg_we: got %b want 1", reg_we); end
      if (reg_we === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++; if ({rd, wb_sel, pc} !== e) begin n_bad++; $display("FAIL add_wb: got %0h want %0h", {rd, wb_sel, pc}, e); end
      end
      imem_valid = 1'b0; imem_data = '0;
      step();
      n_cmp++; if ({pc, reg_we, imem_req, halted} !== {8'h01, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL add_retire: got %0h want %0h", {pc, reg_we, imem_req, halted}, {8'h01, 1'b0, 1'b1, 1'b0}); end
      n_cmp++; if (alu_opcode !== 4'd1) begin n_bad++; $display("FAIL add_opcode_hold: got %0h want 1", alu_opcode); end
   endtask

   task automatic test_load();
      wb_exp_t e;
      int req_cnt;
      do_reset();
      exp_q.push_back({3'd1, 1'b1, 8'h00});
      feed(16'h8243, 0);
      n_cmp++; if ({alu_opcode, alu_src_imm, imm} !== {4'd8, 1'b1, 16'h0003}) begin n_bad++; $display("FAIL ld_decode: got %0h want %0h", {alu_opcode, alu_src_imm, imm}, {4'd8, 1'b1, 16'h0003}); end
      dmem_ready = 1'b1;
      step();
      n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL ld_exec_req: got %b want 0", dmem_req); end
      step();
      req_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         dmem_ready = (i == 3);
         if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cnt++;
         step();
      end
      dmem_ready = 1'b0;
      n_cmp++; if (req_cnt !== 4) begin n_bad++; $display("FAIL ld_req_cycles: got %0d want 4", req_cnt); end
      n_cmp++; if ({dmem_req, reg_we, imem_req} !== 3'b010) begin n_bad++; $display("FAIL ld_wb_state: got %b want 010", {dmem_req, reg_we, imem_req}); end
      if (reg_we === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++; if ({rd, wb_sel, pc} !== e) begin n_bad++; $display("FAIL ld_wb: got %0h want %0h", {rd, wb_sel, pc}, e); end
      end
      step();
      n_cmp++; if ({pc, imem_req, reg_we} !== {8'h01, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ld_retire: got %0h want %0h", {pc, imem_req, reg_we}, {8'h01, 1'b1, 1'b0}); end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (5) begin feed(16'h0000, 0); step(); end
      n_cmp++; if (pc !== 8'h05) begin n_bad++; $display("FAIL br_setup_pc: got %0h want 5", pc); end
      // BNE -2, zero_flag only matters in EXECUTE
      feed(16'hC03E, 0);
      zero_flag = 1'b1;
      step();
      zero_flag = 1'b0;
      n_cmp++; if ({imem_req, reg_we} !== 2'b00) begin n_bad++; $display("FAIL bne_exec: got %b want 00", {imem_req, reg_we}); end
      step();
      n_cmp++; if ({pc, imem_req} !== {8'h04, 1'b1}) begin n_bad++; $display("FAIL bne_taken: got %0h want %0h", {pc, imem_req}, {8'h04, 1'b1}); end
      feed(16'h0000, 0); step();
      feed(16'hC03E, 0);
      step();
      zero_flag = 1'b1;
      step();
      n_cmp++; if (pc !== 8'h06) begin n_bad++; $display("FAIL bne_not_taken: got %0h want 6", pc); end
      feed(16'hB03E, 0);
      step();
      step();
      n_cmp++; if (pc !== 8'h05) begin n_bad++; $display("FAIL beq_taken: got %0h want 5", pc); end
      feed(16'hB03E, 0);
      step();
      zero_flag = 1'b0;
      step();
      n_cmp++; if (pc !== 8'h06) begin n_bad++; $display("FAIL beq_not_taken: got %0h want 6", pc); end
   endtask

   task automatic test_jmp_wrap();
      do_reset();
      repeat (3) begin feed(16'h0000, 1); step(); end
      feed(16'h60FF, 0);
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL jmp_decode_req: got %b want 0", imem_req); end
      step();
      n_cmp++; if ({pc, imem_addr, imem_req} !== {8'hFF, 8'hFF, 1'b1}) begin n_bad++; $display("FAIL jmp_target: got %0h want %0h", {pc, imem_addr, imem_req}, {8'hFF, 8'hFF, 1'b1}); end
      feed(16'h0000, 0);
      step();
      n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL pc_wrap: got %0h want 0", pc); end
   endtask

   task automatic test_illegal();
      do_reset();
      feed(16'h0000, 0); step();
      feed(16'hE000, 0);
      n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse: got %b want 1", illegal); end
      step();
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_width: got %b want 0", illegal); end
`ifdef CTRL_ILLEGAL_TRAP_EN
      imem_valid = 1'b1;
      step(); step();
      imem_valid = 1'b0;
      n_cmp++; if ({halted, imem_req, pc} !== {1'b1, 1'b0, 8'h01}) begin n_bad++; $display("FAIL illegal_trap: got %0h want %0h", {halted, imem_req, pc}, {1'b1, 1'b0, 8'h01}); end
`else
      n_cmp++; if ({halted, imem_req, pc} !== {1'b0, 1'b1, 8'h02}) begin n_bad++; $display("FAIL illegal_as_nop: got %0h want %0h", {halted, imem_req, pc}, {1'b0, 1'b1, 8'h02}); end
`endif
   endtask

   task automatic test_halt();
      do_reset();
      feed(16'h7000, 0);
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_decode: got %b want 0", halted); end
      step();
      imem_valid = 1'b1;
      repeat (3) step();
      imem_valid = 1'b0;
      n_cmp++; if ({halted, imem_req, dmem_req, pc} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin n_bad++; $display("FAIL halt_sticky: got %0h want %0h", {halted, imem_req, dmem_req, pc}, {1'b1, 1'b0, 1'b0, 8'h00}); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if ({halted, imem_req} !== 2'b01) begin n_bad++; $display("FAIL halt_reset: got %b want 01", {halted, imem_req}); end
   endtask

   task automatic test_rst_mem();
      do_reset();
      feed(16'h0000, 0); step();
      feed(16'h9000, 0);
      step();
      step();
      n_cmp++; if ({dmem_req, dmem_we} !== 2'b11) begin n_bad++; $display("FAIL st_mem: got %b want 11", {dmem_req, dmem_we}); end
      step();
      rst = 1'b1;
      dmem_ready = 1'b1;
      #1;
      n_cmp++; if ({dmem_req, dmem_we} !== 2'b00) begin n_bad++; $display("FAIL st_rst_abort: got %b want 00", {dmem_req, dmem_we}); end
      step();
      n_cmp++; if ({pc, imem_req} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL st_rst_state: got %0h want %0h", {pc, imem_req}, {8'h00, 1'b0}); end
      rst = 1'b0;
      #1;
      n_cmp++; if ({imem_req, dmem_req} !== 2'b10) begin n_bad++; $display("FAIL st_rst_release: got %b want 10", {imem_req, dmem_req}); end
      step();
      dmem_ready = 1'b0;
      n_cmp++; if ({pc, imem_req, dmem_req} !== {8'h00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL st_late_ready: got %0h want %0h", {pc, imem_req, dmem_req}, {8'h00, 1'b1, 1'b0}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [8];
      wb_exp_t     e;
      logic [15:0] w;
      logic [3:0]  op;
      logic        done;
      prog = '{16'hA6C5, 16'h2A50, 16'h90C2, 16'h8C01, 16'h3E48, 16'h4400, 16'h5800, 16'h0000};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         w  = prog[i];
         op = w[15:12];
         if ((op >= 4'd1 && op <= 4'd5) || op == 4'd8 || op == 4'd10)
            exp_q.push_back({w[11:9], (op == 4'd8), 8'(i)});
         feed(w, int'($urandom_range(0, 2)));
         done = 1'b0;
         for (int c = 0; c < 30 && !done; c++) begin
            if (imem_req === 1'b1) begin
               done = 1'b1;
            end else begin
               if (reg_we === 1'b1) begin
                  n_cmp++;
                  if (exp_q.size() == 0) begin
                     n_bad++; $display("FAIL b2b_extra_write: got rd %0d want no write", rd);
                  end else begin
                     e = exp_q.pop_front();
                     if ({rd, wb_sel, pc} !== e) begin n_bad++; $display("FAIL b2b_wb: got %0h want %0h", {rd, wb_sel, pc}, e); end
                  end
               end
               dmem_ready = (dmem_req === 1'b1) && ($urandom_range(0, 2) == 0);
               step();
            end
         end
         dmem_ready = 1'b0;
         n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout: got no fetch want fetch for instr %0d", i); end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_missing_writes: got %0d pending want 0", exp_q.size()); end
      n_cmp++; if (pc !== 8'h08) begin n_bad++; $display("FAIL b2b_pc: got %0h want 8", pc); end
   endtask

   initial begin
      rst = 1'b1; imem_valid = 1'b0; imem_data = '0; dmem_ready = 1'b0; zero_flag = 1'b0;
      test_reset();
      test_add();
      test_load();
      test_branch();
      test_jmp_wrap();
      test_illegal();
      test_halt();
      test_rst_mem();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
